fetch_branch_predictor: RTL and testbench
=========================================

// Module: fetch_branch_predictor
// PURPOSE
// - Dual-issue fetch PC generator and branch predictor. Consumes the fetch pre-decoder outputs
//   (per-slot branch flag and sign-extended B-type offset) for the pair fetched at pc_o.
// - Picks the next fetch PC from a 2-bit saturating-counter BHT. Trains on resolved branches
//   from execute, redirects on mispredict and keeps branch/mispredict statistics.
// PARAMETERS
// - BHT_ENTRIES  64            number of 2-bit counters, power of 2, >=2; IDX=$clog2(BHT_ENTRIES)
// - RESET_PC     32'h0000_0000 fetch PC loaded on reset
// PORTS
// - clk            in   1      clock, all state updates on rising edge
// - rst_n          in   1      asynchronous active-low reset
// - stall_i        in   1      fetch stall: hold pc_o (mispredict redirect still wins)
// - branch_en_i    in   2      [s]=1: slot s (PC pc_o+4*s) is a conditional branch, from pre-decoder
// - imm_i          in   2x32   [s] sign-extended branch offset for slot s
// - upd_valid_i    in   1      execute resolved one conditional branch this cycle
// - upd_pc_i       in   32     PC of the resolved branch
// - upd_taken_i    in   1      actual direction
// - upd_mispred_i  in   1      prediction was wrong (only meaningful with upd_valid_i)
// - upd_target_i   in   32     correct next PC after the resolved branch
// - pc_o           out  32     slot-0 fetch PC; slot 1 is pc_o+4
// - pred_taken_o   out  2      per-slot predicted-taken (combinational)
// - flush_o        out  1      registered; kill fetch/decode contents
// - br_cnt_o       out  32     resolved-branch counter, saturating
// - mispred_cnt_o  out  32     mispredict counter, saturating
// BEHAVIOUR
// - Reset (async, rst_n=0): pc_o=RESET_PC, every BHT counter=2'b01 (weak not-taken),
//   flush_o=0, br_cnt_o=0, mispred_cnt_o=0.
// - Lookup (combinational, same cycle as pc_o): idx(s)=(pc_o+4*s)[IDX+1:2].
//   pred_taken_o[s] = branch_en_i[s] & BHT[idx(s)][1].
// - Next PC, priority order (registered, 1-cycle latency):
//   1. upd_valid_i & upd_mispred_i -> upd_target_i, even when stall_i=1
//   2. stall_i                     -> hold pc_o
//   3. pred_taken_o[0]             -> pc_o + imm_i[0]; slot 1 is ignored
//   4. pred_taken_o[1]             -> pc_o + 4 + imm_i[1]
//   5. otherwise                   -> pc_o + 8
// - All adds are 32-bit modulo 2^32: wrap-around is silent, no alignment check.
// - Training: on upd_valid_i, counter at upd_pc_i[IDX+1:2] moves +1 if taken, -1 if not,
//   saturating at 2'b11 / 2'b00. Training is independent of stall_i.
// - Same-index read/write in one cycle: lookup returns the pre-update value (no bypass).
//   The write lands at the clock edge.
// - flush_o = 1 exactly the cycle after a cycle with upd_valid_i & upd_mispred_i; 0 otherwise.
//   Back-to-back mispredicts hold flush_o high on consecutive cycles.
// - br_cnt_o +1 per upd_valid_i; mispred_cnt_o +1 per upd_valid_i & upd_mispred_i.
//   Both saturate at 32'hFFFF_FFFF.
// - upd_mispred_i without upd_valid_i is ignored entirely.
// - Reset asserted mid-operation: all state returns to reset values immediately,
//   with no dependence on clk.
// TESTING
// - Reset, no branches, stall_i=0 -> pc_o 0,8,16,24; pred_taken_o=0; flush_o=0.
// - branch_en_i=2'b01, imm_i[0]=-16 at pc 0x40: cold, pc_o goes 0x48. Train two taken updates
//   at upd_pc=0x40, then refetch 0x40 -> pred_taken_o=01, next pc_o=0x30.
// - Slot-1 branch at 0x44 trained taken, imm_i[1]=0x100, fetch pc 0x40 -> next pc_o=0x144.
//   With slot 0 also predicted taken, slot 0 wins.
// - stall_i=1 with upd_valid_i=1, upd_mispred_i=1, upd_target_i=0x200 -> next pc_o=0x200,
//   flush_o=1 for 1 cycle, mispred_cnt_o +1.
// - Five taken then five not-taken updates to one index -> counter 11 (saturated),
//   then 00 (saturated); read on the same-cycle write sees the old value.
// - Assert rst_n low between clock edges mid-run -> pc_o=RESET_PC, counters and stats 0
//   with no clock edge needed.

Source files
------------

// File: rtl/fetch_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : fetch_branch_predictor
// Description : Dual-issue fetch PC generator with a 2-bit saturating-counter
//               branch history table (BHT). Predicts the next fetch PC for
//               the instruction pair at pc_o. Trains the BHT from branches
//               resolved in execute. Redirects fetch on a mispredict and
//               keeps statistics on resolved branches and mispredicts.
// Ports       : clk, rst_n              clock / async active-low reset
//               stall_i                 hold pc_o (a redirect still wins)
//               branch_en_i, imm_i      pre-decoder info per fetch slot
//               upd_*_i                 resolved-branch feedback from execute
//               pc_o, pred_taken_o      fetch PC and per-slot prediction
//               flush_o                 registered kill of fetch/decode
//               br_cnt_o, mispred_cnt_o saturating statistics counters
// Revision    : 1.0  initial release
// ============================================================================
module fetch_branch_predictor #(
    parameter int          BHT_ENTRIES = 64,
    parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic [1:0]       branch_en_i,
    input  logic [1:0][31:0] imm_i,
    input  logic             upd_valid_i,
    input  logic [31:0]      upd_pc_i,
    input  logic             upd_taken_i,
    input  logic             upd_mispred_i,
    input  logic [31:0]      upd_target_i,
    output logic [31:0]      pc_o,
    output logic [1:0]       pred_taken_o,
    output logic             flush_o,
    output logic [31:0]      br_cnt_o,
    output logic [31:0]      mispred_cnt_o
);

    localparam int IDX = $clog2(BHT_ENTRIES);

    logic [31:0]    r_pc;
    logic [1:0]     r_bht [BHT_ENTRIES];
    logic           r_flush;
    logic [31:0]    r_br_cnt;
    logic [31:0]    r_mispred_cnt;

    logic [31:0]    w_pc1;
    logic [IDX-1:0] w_idx0;
    logic [IDX-1:0] w_idx1;
    logic [IDX-1:0] w_upd_idx;
    logic [1:0]     w_pred;
    logic           w_redirect;
    logic [31:0]    w_next_pc;
    logic [1:0]     w_cnt_cur;
    logic [1:0]     w_cnt_next;

    // Only the index bits of the update PC address the table.
    logic           w_unused_upd_pc;
    assign w_unused_upd_pc = ^{upd_pc_i[31:IDX+2], upd_pc_i[1:0]};

    // ------------------------------------------------------------------------
    // Lookup: both slots read the table combinationally. A write issued in
    // the same cycle is not bypassed; it becomes visible after the edge.
    // ------------------------------------------------------------------------
    assign w_pc1  = r_pc + 32'd4;
    assign w_idx0 = r_pc[IDX+1:2];
    assign w_idx1 = w_pc1[IDX+1:2];

    assign w_pred[0] = branch_en_i[0] & r_bht[w_idx0][1];
    assign w_pred[1] = branch_en_i[1] & r_bht[w_idx1][1];

    // A mispredict only counts when it comes with a valid update.
    assign w_redirect = upd_valid_i & upd_mispred_i;

    // ------------------------------------------------------------------------
    // Next-PC selection. The redirect overrides a stall. A taken slot 0
    // makes slot 1 dead, so slot 0 is checked first.
    // ------------------------------------------------------------------------
    always_comb begin
        w_next_pc = r_pc + 32'd8;
        if (w_redirect) begin
            w_next_pc = upd_target_i;
        end else if (stall_i) begin
            w_next_pc = r_pc;
        end else if (w_pred[0]) begin
            w_next_pc = r_pc + imm_i[0];
        end else if (w_pred[1]) begin
            w_next_pc = w_pc1 + imm_i[1];
        end
    end

    // ------------------------------------------------------------------------
    // Training: the 2-bit counter saturates in both directions.
    // ------------------------------------------------------------------------
    assign w_upd_idx = upd_pc_i[IDX+1:2];
    assign w_cnt_cur = r_bht[w_upd_idx];

    always_comb begin
        w_cnt_next = w_cnt_cur;
        if (upd_taken_i) begin
            if (w_cnt_cur != 2'b11) begin
                w_cnt_next = w_cnt_cur + 2'b01;
            end
        end else begin
            if (w_cnt_cur != 2'b00) begin
                w_cnt_next = w_cnt_cur - 2'b01;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_flush       <= 1'b0;
            r_br_cnt      <= 32'd0;
            r_mispred_cnt <= 32'd0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                r_bht[i] <= 2'b01;
            end
        end else begin
            r_pc    <= w_next_pc;
            r_flush <= w_redirect;
            if (upd_valid_i) begin
                r_bht[w_upd_idx] <= w_cnt_next;
                if (r_br_cnt != 32'hFFFF_FFFF) begin
                    r_br_cnt <= r_br_cnt + 32'd1;
                end
            end
            if (w_redirect && (r_mispred_cnt != 32'hFFFF_FFFF)) begin
                r_mispred_cnt <= r_mispred_cnt + 32'd1;
            end
        end
    end

    assign pc_o          = r_pc;
    assign pred_taken_o  = w_pred;
    assign flush_o       = r_flush;
    assign br_cnt_o      = r_br_cnt;
    assign mispred_cnt_o = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fetch_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_branch_predictor
// Description : Self-checking bench for fetch_branch_predictor. It applies a
//               directed vector table, then hand-written saturation and
//               asynchronous-reset sequences, then random traffic checked
//               against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fetch_branch_predictor;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             stall_i;
    logic [1:0]       branch_en_i;
    logic [1:0][31:0] imm_i;
    logic             upd_valid_i;
    logic [31:0]      upd_pc_i;
    logic             upd_taken_i;
    logic             upd_mispred_i;
    logic [31:0]      upd_target_i;
    logic [31:0]      pc_o;
    logic [1:0]       pred_taken_o;
    logic             flush_o;
    logic [31:0]      br_cnt_o;
    logic [31:0]      mispred_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fetch_branch_predictor #(
        .BHT_ENTRIES (64),
        .RESET_PC    (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .branch_en_i   (branch_en_i),
        .imm_i         (imm_i),
        .upd_valid_i   (upd_valid_i),
        .upd_pc_i      (upd_pc_i),
        .upd_taken_i   (upd_taken_i),
        .upd_mispred_i (upd_mispred_i),
        .upd_target_i  (upd_target_i),
        .pc_o          (pc_o),
        .pred_taken_o  (pred_taken_o),
        .flush_o       (flush_o),
        .br_cnt_o      (br_cnt_o),
        .mispred_cnt_o (mispred_cnt_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [1:0] be, input logic [31:0] i0,
                         input logic [31:0] i1, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic um, input logic [31:0] utgt);
        stall_i       = st;
        branch_en_i   = be;
        imm_i[0]      = i0;
        imm_i[1]      = i1;
        upd_valid_i   = uv;
        upd_pc_i      = upc;
        upd_taken_i   = ut;
        upd_mispred_i = um;
        upd_target_i  = utgt;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    endtask

    // Leaves the bench at posedge+1 with reset released.
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic        st;
        logic [1:0]  be;
        logic [31:0] i0;
        logic [31:0] i1;
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic        um;
        logic [31:0] utgt;
        logic [1:0]  exp_pred;
        logic [31:0] exp_pc;
        logic        exp_flush;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic st, input logic [1:0] be, input logic [31:0] i0,
                       input logic [31:0] i1, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic um, input logic [31:0] utgt,
                       input logic [1:0] ep, input logic [31:0] epc, input logic ef);
        vec_t v;
        v = '{st, be, i0, i1, uv, upc, ut, um, utgt, ep, epc, ef};
        vecs.push_back(v);
    endtask

    // ------------------------------------------------------------------------
    // Behavioural reference model for random traffic
    // ------------------------------------------------------------------------
    logic [31:0] m_pc;
    int          m_bht [64];
    logic        m_flush;
    longint      m_br;
    longint      m_mis;

    function automatic int midx(input logic [31:0] a);
        return int'((a >> 2) % 64);
    endfunction

    task automatic model_reset();
        m_pc = 32'd0;
        m_flush = 1'b0;
        m_br = 0;
        m_mis = 0;
        for (int i = 0; i < 64; i++) m_bht[i] = 1;
    endtask

    initial begin
        int exp_br;
        int exp_mis;
        int cnt;
        logic [1:0] ep;
        string nm;

        rst_n = 1'b1;
        idle_inputs();
        #2;
        do_reset();

        // Reset state
        branch_en_i = 2'b11;
        #1;
        chk("reset_pc", pc_o, 32'h0);
        chk("reset_flush", {31'd0, flush_o}, 32'd0);
        chk("reset_br_cnt", br_cnt_o, 32'd0);
        chk("reset_mis_cnt", mispred_cnt_o, 32'd0);
        chk("reset_pred_weak_nt", {30'd0, pred_taken_o}, 32'd0);
        idle_inputs();
        @(posedge clk);
        #1;
        do_reset();

        // Table: sequential scenario from reset
        add(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h08, 0);
        add(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h10, 0);
        add(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h18, 0);
        add(0, 2'b00, 0, 0, 1, 32'h80, 1, 1, 32'h40, 2'b00, 32'h40, 1);
        add(0, 2'b01, -32'sd16, 0, 0, 0, 0, 0, 0, 2'b00, 32'h48, 0);
        add(0, 2'b00, 0, 0, 1, 32'h40, 1, 0, 0, 2'b00, 32'h50, 0);
        add(0, 2'b00, 0, 0, 1, 32'h40, 1, 0, 0, 2'b00, 32'h58, 0);
        add(0, 2'b00, 0, 0, 1, 32'h80, 1, 1, 32'h40, 2'b00, 32'h40, 1);
        add(0, 2'b01, -32'sd16, 0, 0, 0, 0, 0, 0, 2'b01, 32'h30, 0);
        add(0, 2'b00, 0, 0, 1, 32'h44, 1, 0, 0, 2'b00, 32'h38, 0);
        add(0, 2'b00, 0, 0, 1, 32'h44, 1, 0, 0, 2'b00, 32'h40, 0);
        add(0, 2'b10, 0, 32'h100, 0, 0, 0, 0, 0, 2'b10, 32'h144, 0);
        add(0, 2'b00, 0, 0, 1, 32'h80, 1, 1, 32'h40, 2'b00, 32'h40, 1);
        add(0, 2'b11, -32'sd16, 32'h100, 0, 0, 0, 0, 0, 2'b11, 32'h30, 0);
        add(1, 2'b00, 0, 0, 1, 32'h80, 1, 1, 32'h200, 2'b00, 32'h200, 1);
        add(1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 2'b00, 32'h200, 0);
        add(0, 2'b00, 0, 0, 0, 0, 0, 1, 32'h999, 2'b00, 32'h208, 0);

        exp_br = 0;
        exp_mis = 0;
        foreach (vecs[i]) begin
            drive(vecs[i].st, vecs[i].be, vecs[i].i0, vecs[i].i1, vecs[i].uv,
                  vecs[i].upc, vecs[i].ut, vecs[i].um, vecs[i].utgt);
            if (vecs[i].uv) exp_br++;
            if (vecs[i].uv && vecs[i].um) exp_mis++;
            #1;
            nm = $sformatf("vec%0d_pred", i);
            chk(nm, {30'd0, pred_taken_o}, {30'd0, vecs[i].exp_pred});
            @(posedge clk);
            #1;
            nm = $sformatf("vec%0d_pc", i);
            chk(nm, pc_o, vecs[i].exp_pc);
            nm = $sformatf("vec%0d_flush", i);
            chk(nm, {31'd0, flush_o}, {31'd0, vecs[i].exp_flush});
        end
        chk("table_br_cnt", br_cnt_o, 32'(exp_br));
        chk("table_mis_cnt", mispred_cnt_o, 32'(exp_mis));

        // Saturation and same-cycle read/write at index 0 (pc held at 0).
        do_reset();
        cnt = 1;
        for (int k = 0; k < 12; k++) begin
            logic t;
            t = (k < 5) || (k >= 10);
            drive(1'b1, 2'b01, 32'h100, 32'd0, 1'b1, 32'h0, t, 1'b0, 32'd0);
            #1;
            ep = {1'b0, cnt >= 2};
            nm = $sformatf("sat%0d_pred_old", k);
            chk(nm, {30'd0, pred_taken_o}, {30'd0, ep});
            @(posedge clk);
            #1;
            cnt = t ? ((cnt < 3) ? cnt + 1 : 3) : ((cnt > 0) ? cnt - 1 : 0);
        end
        idle_inputs();
        branch_en_i = 2'b01;
        stall_i = 1'b1;
        #1;
        chk("sat_final_pred", {30'd0, pred_taken_o}, {30'd0, 1'b0, cnt >= 2});

        // Asynchronous reset mid-run: move state away from reset, then pull
        // rst_n low between edges.
        drive(1'b0, 2'b00, 0, 0, 1'b1, 32'h80, 1'b1, 1'b1, 32'h300);
        @(posedge clk);
        #3;
        idle_inputs();
        branch_en_i = 2'b01;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pc", pc_o, 32'h0);
        chk("async_rst_flush", {31'd0, flush_o}, 32'd0);
        chk("async_rst_br", br_cnt_o, 32'd0);
        chk("async_rst_mis", mispred_cnt_o, 32'd0);
        chk("async_rst_bht", {30'd0, pred_taken_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Randomised traffic against the model.
        do_reset();
        model_reset();
        for (int k = 0; k < 3000; k++) begin
            logic        st, uv, ut, um;
            logic [1:0]  be;
            logic [31:0] i0, i1, upc, utgt, nxt;
            logic [1:0]  mp;
            st   = ($urandom_range(0, 7) == 0);
            be   = 2'($urandom);
            i0   = $urandom_range(0, 1) ? -32'($urandom_range(0, 64) * 4) : 32'($urandom_range(0, 64) * 4);
            i1   = $urandom_range(0, 1) ? -32'($urandom_range(0, 64) * 4) : 32'($urandom_range(0, 64) * 4);
            uv   = ($urandom_range(0, 2) != 0);
            upc  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_00FC);
            ut   = ($urandom_range(0, 2) != 0);
            um   = ($urandom_range(0, 9) == 0);
            utgt = $urandom & 32'hFFFF_FFFC;
            if (k % 500 == 499) utgt = 32'hFFFF_FFFC;
            drive(st, be, i0, i1, uv, upc, ut, um, utgt);

            mp[0] = be[0] && (m_bht[midx(m_pc)] >= 2);
            mp[1] = be[1] && (m_bht[midx(m_pc + 32'd4)] >= 2);
            if (uv && um)   nxt = utgt;
            else if (st)    nxt = m_pc;
            else if (mp[0]) nxt = m_pc + i0;
            else if (mp[1]) nxt = m_pc + 32'd4 + i1;
            else            nxt = m_pc + 32'd8;

            #1;
            chk("rnd_pred", {30'd0, pred_taken_o}, {30'd0, mp});

            m_pc = nxt;
            m_flush = uv && um;
            if (uv) begin
                m_br = (m_br < 64'hFFFF_FFFF) ? m_br + 1 : m_br;
                if (ut) m_bht[midx(upc)] = (m_bht[midx(upc)] < 3) ? m_bht[midx(upc)] + 1 : 3;
                else    m_bht[midx(upc)] = (m_bht[midx(upc)] > 0) ? m_bht[midx(upc)] - 1 : 0;
                if (um) m_mis = (m_mis < 64'hFFFF_FFFF) ? m_mis + 1 : m_mis;
            end

            @(posedge clk);
            #1;
            chk("rnd_pc", pc_o, m_pc);
            chk("rnd_flush", {31'd0, flush_o}, {31'd0, m_flush});
            chk("rnd_br_cnt", br_cnt_o, 32'(m_br));
            chk("rnd_mis_cnt", mispred_cnt_o, 32'(m_mis));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
